// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and constants for the parking request generator
// Contents: FSM state enum, passcode/counter widths, direction encodings.
package parking_pkg;

    localparam int PASSCODE_W = 8;
    localparam int COUNT_W    = 5;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE_ENTRY = 3'd1,
        ST_WAIT_ENTRY  = 3'd2,
        ST_ISSUE_EXIT  = 3'd3,
        ST_WAIT_EXIT   = 3'd4,
        ST_COOLDOWN    = 3'd5
    } state_t;

endpackage

// File: rtl/parking_keypad_assembler.sv
// rtl/parking_keypad_assembler.sv - two-digit keypad code assembly with hold and clear
// Ports: clk, reset_n (async active-low), key_valid/key_digit/key_clear from keypad,
//        hold (freeze code while it is being presented), flush (drop code after use),
//        code (assembled passcode), code_ready (two digits held).
module parking_keypad_assembler
    import parking_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  key_valid,
    input  logic [3:0]            key_digit,
    input  logic                  key_clear,
    input  logic                  hold,
    input  logic                  flush,
    output logic [PASSCODE_W-1:0] code,
    output logic                  code_ready
);

    logic have_first;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code       <= '0;
            have_first <= 1'b0;
            code_ready <= 1'b0;
        end else if (flush) begin
            code       <= '0;
            have_first <= 1'b0;
            code_ready <= 1'b0;
        end else if (!hold) begin
            // While the code is being presented to the controller, neither
            // digits nor a clear may disturb it.
            if (key_clear) begin
                code       <= '0;
                have_first <= 1'b0;
                code_ready <= 1'b0;
            end else if (key_valid && !code_ready) begin
                if (!have_first) begin
                    code[7:4]  <= key_digit;
                    have_first <= 1'b1;
                end else begin
                    code[3:0]  <= key_digit;
                    code_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/parking_request_gen.sv
// rtl/parking_request_gen.sv - sensor/keypad front-end issuing gate requests to the controller
// Optional feature macro: PARKING_REQ_STATS_EN (adds grant_cnt/deny_cnt outputs).
// Ports: clk, reset_n (async active-low); key_valid/key_digit/key_clear keypad;
//        entry_sensor/exit_sensor car presence; entry_gate_open/exit_gate_open from controller;
//        enter_req/exit_req/passcode_in to controller; grant/deny/grant_dir outcome;
//        busy, code_ready status; grant_cnt/deny_cnt saturating counts (stats build only).
module parking_request_gen
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 6,
    parameter int COOLDOWN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  key_valid,
    input  logic [3:0]            key_digit,
    input  logic                  key_clear,
    input  logic                  entry_sensor,
    input  logic                  exit_sensor,
    input  logic                  entry_gate_open,
    input  logic                  exit_gate_open,
    output logic                  enter_req,
    output logic                  exit_req,
    output logic [PASSCODE_W-1:0] passcode_in,
    output logic                  grant,
    output logic                  deny,
    output logic                  grant_dir,
    output logic                  busy,
    output logic                  code_ready
`ifdef PARKING_REQ_STATS_EN
    ,
    output logic [7:0]            grant_cnt,
    output logic [7:0]            deny_cnt
`endif
);

    state_t                state, state_next;
    logic [COUNT_W-1:0]    cnt;
    logic                  entry_r, entry_r_d, exit_r, exit_r_d;
    logic                  entry_pend, exit_pend;
    logic                  last_served, last_valid;
    logic [PASSCODE_W-1:0] code;

    logic wait_entry, wait_exit, timeout;
    logic done_entry, done_exit, entry_ok, exit_ok;

    assign wait_entry = (state == ST_WAIT_ENTRY);
    assign wait_exit  = (state == ST_WAIT_EXIT);
    assign timeout    = (cnt == COUNT_W'(TIMEOUT_CYCLES));
    assign done_entry = wait_entry && (entry_gate_open || timeout);
    assign done_exit  = wait_exit  && (exit_gate_open  || timeout);
    assign entry_ok   = entry_pend && code_ready;
    assign exit_ok    = exit_pend;

    parking_keypad_assembler u_keypad (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_clear  (key_clear),
        .hold       (state == ST_ISSUE_ENTRY || wait_entry),
        .flush      (done_entry),
        .code       (code),
        .code_ready (code_ready)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                // With no history yet, entry wins a tie; afterwards the tie
                // goes to the direction not served last.
                if (entry_ok && exit_ok)
                    state_next = (last_valid && last_served == DIR_ENTRY) ? ST_ISSUE_EXIT : ST_ISSUE_ENTRY;
                else if (entry_ok)
                    state_next = ST_ISSUE_ENTRY;
                else if (exit_ok)
                    state_next = ST_ISSUE_EXIT;
            end
            ST_ISSUE_ENTRY: state_next = ST_WAIT_ENTRY;
            ST_WAIT_ENTRY:  if (done_entry) state_next = ST_COOLDOWN;
            ST_ISSUE_EXIT:  state_next = ST_WAIT_EXIT;
            ST_WAIT_EXIT:   if (done_exit) state_next = ST_COOLDOWN;
            // The arbitration cycle in IDLE is the last of the idle cycles,
            // so COOLDOWN itself lasts one cycle fewer.
            ST_COOLDOWN:    if (cnt == COUNT_W'(COOLDOWN_CYCLES - 2)) state_next = ST_IDLE;
            default:        state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            entry_r     <= 1'b0;
            entry_r_d   <= 1'b0;
            exit_r      <= 1'b0;
            exit_r_d    <= 1'b0;
            entry_pend  <= 1'b0;
            exit_pend   <= 1'b0;
            last_served <= DIR_ENTRY;
            last_valid  <= 1'b0;
            enter_req   <= 1'b0;
            exit_req    <= 1'b0;
        end else begin
            state     <= state_next;
            entry_r   <= entry_sensor;
            entry_r_d <= entry_r;
            exit_r    <= exit_sensor;
            exit_r_d  <= exit_r;
            // Counter is 0 in ISSUE and counts on through WAIT, so in WAIT
            // it equals the number of cycles since the request pulse.
            if (state_next != state && state_next != ST_WAIT_ENTRY && state_next != ST_WAIT_EXIT)
                cnt <= '0;
            else if (state != ST_IDLE)
                cnt <= cnt + COUNT_W'(1);
            entry_pend <= (entry_r && !entry_r_d) || (entry_pend && !done_entry);
            exit_pend  <= (exit_r && !exit_r_d)   || (exit_pend  && !done_exit);
            if (done_entry) begin
                last_served <= DIR_ENTRY;
                last_valid  <= 1'b1;
            end else if (done_exit) begin
                last_served <= DIR_EXIT;
                last_valid  <= 1'b1;
            end
            enter_req <= (state_next == ST_ISSUE_ENTRY);
            exit_req  <= (state_next == ST_ISSUE_EXIT);
        end
    end

    assign grant       = (wait_entry && entry_gate_open) || (wait_exit && exit_gate_open);
    assign deny        = (wait_entry && !entry_gate_open && timeout) || (wait_exit && !exit_gate_open && timeout);
    assign grant_dir   = wait_exit ? DIR_EXIT : (wait_entry ? DIR_ENTRY : last_served);
    assign busy        = (state != ST_IDLE);
    assign passcode_in = (state == ST_ISSUE_ENTRY || wait_entry) ? code : '0;

`ifdef PARKING_REQ_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt <= 8'h00;
            deny_cnt  <= 8'h00;
        end else begin
            if (grant && grant_cnt != 8'hFF) grant_cnt <= grant_cnt + 8'h01;
            if (deny  && deny_cnt  != 8'hFF) deny_cnt  <= deny_cnt  + 8'h01;
        end
    end
`endif

endmodule
